// File: rtl/branch_pkg.sv
// Shared definitions for the branch resolution stage: funct3 codes,
// 2-bit BHT counter encodings and the PC-to-BHT index helper.
package branch_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bht_cnt_e;

    // Word-aligned PCs: drop the two byte-offset bits, keep idx_w bits.
    function automatic int unsigned idx_of(input logic [63:0] pc, input int unsigned idx_w);
        logic [63:0] mask;
        mask = (64'd1 << idx_w) - 64'd1;
        return 32'((pc >> 2) & mask);
    endfunction

endpackage

// File: rtl/branch_resolve_unit_bht.sv
// 2-bit saturating-counter branch history table: asynchronous read port,
// one synchronous update port, asynchronous reset to weakly not-taken.
module bht_2bit
    import branch_pkg::*;
#(
    parameter int unsigned BHT_ENTRIES = 64,
    parameter int unsigned XLEN        = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic [XLEN-1:0] rd_pc_i,
    output logic            rd_taken_o,
    input  logic            upd_en_i,
    input  logic [XLEN-1:0] upd_pc_i,
    input  logic            upd_taken_i
);

    localparam int unsigned IDX_W = $clog2(BHT_ENTRIES);

    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] wr_idx;
    bht_cnt_e         cnt_q [BHT_ENTRIES];
    bht_cnt_e         cnt_d;

    assign rd_idx = IDX_W'(idx_of(64'(rd_pc_i), IDX_W));
    assign wr_idx = IDX_W'(idx_of(64'(upd_pc_i), IDX_W));

    // No write-to-read bypass: a same-cycle lookup sees the old counter.
    assign rd_taken_o = (cnt_q[rd_idx] == WT) || (cnt_q[rd_idx] == ST);

    always_comb begin
        cnt_d = cnt_q[wr_idx];
        case (cnt_q[wr_idx])
            SNT:     cnt_d = upd_taken_i ? WNT : SNT;
            WNT:     cnt_d = upd_taken_i ? WT  : SNT;
            WT:      cnt_d = upd_taken_i ? ST  : WNT;
            ST:      cnt_d = upd_taken_i ? ST  : WT;
            default: cnt_d = WNT;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < BHT_ENTRIES; i++) begin
                cnt_q[i] <= WNT;
            end
        end else if (upd_en_i) begin
            cnt_q[wr_idx] <= cnt_d;
        end
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Registered RV32I branch resolution: own comparator, mispredict redirect,
// BHT training and saturating branch/mispredict statistics.
module branch_resolve_unit
    import branch_pkg::*;
#(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned BHT_ENTRIES = 64,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             valid_i,
    input  logic             branch_i,
    input  logic [2:0]       funct3_i,
    input  logic [XLEN-1:0]  rs1_i,
    input  logic [XLEN-1:0]  rs2_i,
    input  logic [XLEN-1:0]  pc_i,
    input  logic [XLEN-1:0]  target_i,
    input  logic             pred_taken_i,
    input  logic             flush_i,
    input  logic [XLEN-1:0]  lookup_pc_i,
    output logic             lookup_taken_o,
    output logic             valid_o,
    output logic             take_branch_o,
    output logic             mispredict_o,
    output logic [XLEN-1:0]  redirect_pc_o,
    output logic             illegal_o,
    output logic [CNT_W-1:0] branch_cnt_o,
    output logic [CNT_W-1:0] mispred_cnt_o
);

    logic             accept;
    logic             take_d;
    logic             illegal_d;
    logic             mis_d;
    logic [XLEN-1:0]  redirect_d;

    logic             valid_q;
    logic             take_q;
    logic             mis_q;
    logic             illegal_q;
    logic [XLEN-1:0]  redirect_q;
    logic [XLEN-1:0]  pc_q;
    logic [CNT_W-1:0] branch_cnt_q;
    logic [CNT_W-1:0] mispred_cnt_q;

    assign accept = valid_i & branch_i & ~flush_i;

    always_comb begin
        take_d    = 1'b0;
        illegal_d = 1'b0;
        case (funct3_i)
            F3_BEQ:  take_d = (rs1_i == rs2_i);
            F3_BNE:  take_d = (rs1_i != rs2_i);
            F3_BLT:  take_d = ($signed(rs1_i) <  $signed(rs2_i));
            F3_BGE:  take_d = ($signed(rs1_i) >= $signed(rs2_i));
            F3_BLTU: take_d = (rs1_i <  rs2_i);
            F3_BGEU: take_d = (rs1_i >= rs2_i);
            default: illegal_d = 1'b1;
        endcase

        // Illegal encodings resolve as not-taken, so a taken prediction
        // redirects to the fall-through PC like any other mispredict.
        mis_d      = take_d ^ pred_taken_i;
        redirect_d = '0;
        if (take_d && !pred_taken_i) begin
            redirect_d = target_i;
        end else if (!take_d && pred_taken_i) begin
            redirect_d = pc_i + XLEN'(4);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q       <= 1'b0;
            take_q        <= 1'b0;
            mis_q         <= 1'b0;
            illegal_q     <= 1'b0;
            redirect_q    <= '0;
            pc_q          <= '0;
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            valid_q    <= accept;
            take_q     <= accept & take_d;
            mis_q      <= accept & mis_d;
            illegal_q  <= accept & illegal_d;
            redirect_q <= accept ? redirect_d : '0;
            pc_q       <= pc_i;
            if (valid_q && (branch_cnt_q != '1)) begin
                branch_cnt_q <= branch_cnt_q + CNT_W'(1);
            end
            if (valid_q && mis_q && (mispred_cnt_q != '1)) begin
                mispred_cnt_q <= mispred_cnt_q + CNT_W'(1);
            end
        end
    end

    bht_2bit #(
        .BHT_ENTRIES (BHT_ENTRIES),
        .XLEN        (XLEN)
    ) u_bht (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .rd_pc_i     (lookup_pc_i),
        .rd_taken_o  (lookup_taken_o),
        .upd_en_i    (valid_q & ~illegal_q),
        .upd_pc_i    (pc_q),
        .upd_taken_i (take_q)
    );

    assign valid_o       = valid_q;
    assign take_branch_o = take_q;
    assign mispredict_o  = mis_q;
    assign redirect_pc_o = redirect_q;
    assign illegal_o     = illegal_q;
    assign branch_cnt_o  = branch_cnt_q;
    assign mispred_cnt_o = mispred_cnt_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit with a one-deep result scoreboard
// and a reference BHT/statistics model.
module tb_branch_resolve_unit;

    localparam int unsigned XL   = 32;
    localparam int unsigned NE   = 16;
    localparam int unsigned CW   = 6;
    localparam int          CMAX = 63;

    logic          clk = 1'b0;
    logic          rst_ni = 1'b0;
    logic          valid_i = 1'b0;
    logic          branch_i = 1'b0;
    logic [2:0]    funct3_i = 3'b000;
    logic [XL-1:0] rs1_i = '0;
    logic [XL-1:0] rs2_i = '0;
    logic [XL-1:0] pc_i = '0;
    logic [XL-1:0] target_i = '0;
    logic          pred_taken_i = 1'b0;
    logic          flush_i = 1'b0;
    logic [XL-1:0] lookup_pc_i = '0;
    logic          lookup_taken_o;
    logic          valid_o;
    logic          take_branch_o;
    logic          mispredict_o;
    logic [XL-1:0] redirect_pc_o;
    logic          illegal_o;
    logic [CW-1:0] branch_cnt_o;
    logic [CW-1:0] mispred_cnt_o;

    branch_resolve_unit #(
        .XLEN        (XL),
        .BHT_ENTRIES (NE),
        .CNT_W       (CW)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .valid_i        (valid_i),
        .branch_i       (branch_i),
        .funct3_i       (funct3_i),
        .rs1_i          (rs1_i),
        .rs2_i          (rs2_i),
        .pc_i           (pc_i),
        .target_i       (target_i),
        .pred_taken_i   (pred_taken_i),
        .flush_i        (flush_i),
        .lookup_pc_i    (lookup_pc_i),
        .lookup_taken_o (lookup_taken_o),
        .valid_o        (valid_o),
        .take_branch_o  (take_branch_o),
        .mispredict_o   (mispredict_o),
        .redirect_pc_o  (redirect_pc_o),
        .illegal_o      (illegal_o),
        .branch_cnt_o   (branch_cnt_o),
        .mispred_cnt_o  (mispred_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          valid;
        logic          take;
        logic          mis;
        logic          ill;
        logic [XL-1:0] redirect;
        logic [XL-1:0] pc;
    } exp_t;

    exp_t sb[$];
    exp_t pending;
    int   mbht [NE];
    int   bcnt;
    int   mcnt;
    int   checks = 0;
    int   errors = 0;

    function automatic int midx(input logic [XL-1:0] pc);
        return int'((pc >> 2) % NE);
    endfunction

    function automatic exp_t idle_exp();
        exp_t e;
        e.valid = 1'b0; e.take = 1'b0; e.mis = 1'b0; e.ill = 1'b0;
        e.redirect = '0; e.pc = '0;
        return e;
    endfunction

    function automatic exp_t predict(input logic acc, input logic [2:0] f3,
                                     input logic [XL-1:0] a, input logic [XL-1:0] b,
                                     input logic [XL-1:0] pc, input logic [XL-1:0] tgt,
                                     input logic pt);
        exp_t e;
        e = idle_exp();
        if (acc) begin
            e.valid = 1'b1;
            e.pc    = pc;
            case (f3)
                3'd0: e.take = (a == b);
                3'd1: e.take = (a != b);
                3'd4: e.take = ($signed(a) <  $signed(b));
                3'd5: e.take = ($signed(a) >= $signed(b));
                3'd6: e.take = (a <  b);
                3'd7: e.take = (a >= b);
                default: e.ill = 1'b1;
            endcase
            e.mis = (e.take != pt);
            if (e.take && !pt)      e.redirect = tgt;
            else if (!e.take && pt) e.redirect = pc + 32'd4;
        end
        return e;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NE; i++) mbht[i] = 1;
        bcnt = 0;
        mcnt = 0;
        pending = idle_exp();
        sb.delete();
    endtask

    task automatic apply(input exp_t e);
        int i;
        if (e.valid) begin
            if (!e.ill) begin
                i = midx(e.pc);
                if (e.take) mbht[i] = (mbht[i] == 3) ? 3 : mbht[i] + 1;
                else        mbht[i] = (mbht[i] == 0) ? 0 : mbht[i] - 1;
            end
            bcnt = (bcnt == CMAX) ? CMAX : bcnt + 1;
            if (e.mis) mcnt = (mcnt == CMAX) ? CMAX : mcnt + 1;
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input exp_t e);
        chk("valid_o",        64'(valid_o),        64'(e.valid));
        chk("take_branch_o",  64'(take_branch_o),  64'(e.take));
        chk("mispredict_o",   64'(mispredict_o),   64'(e.mis));
        chk("illegal_o",      64'(illegal_o),      64'(e.ill));
        chk("redirect_pc_o",  64'(redirect_pc_o),  64'(e.redirect));
        chk("branch_cnt_o",   64'(branch_cnt_o),   64'(bcnt));
        chk("mispred_cnt_o",  64'(mispred_cnt_o),  64'(mcnt));
        chk("lookup_taken_o", 64'(lookup_taken_o), 64'(mbht[midx(lookup_pc_i)] >= 2));
    endtask

    // Drive one cycle, retire the previous result into the model, then
    // check the result for this cycle's instruction.
    task automatic step(input logic v, input logic br, input logic [2:0] f3,
                        input logic [XL-1:0] a, input logic [XL-1:0] b,
                        input logic [XL-1:0] pc, input logic [XL-1:0] tgt,
                        input logic pt, input logic fl, input logic [XL-1:0] lk);
        valid_i = v; branch_i = br; funct3_i = f3; rs1_i = a; rs2_i = b;
        pc_i = pc; target_i = tgt; pred_taken_i = pt; flush_i = fl; lookup_pc_i = lk;
        sb.push_back(predict(v & br & ~fl, f3, a, b, pc, tgt, pt));
        @(posedge clk);
        #1;
        apply(pending);
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 64'(sb.size()), 64'd1);
        end else begin
            pending = sb.pop_front();
            check_all(pending);
        end
    endtask

    task automatic br(input logic [2:0] f3, input logic [XL-1:0] a, input logic [XL-1:0] b,
                      input logic [XL-1:0] pc, input logic [XL-1:0] tgt, input logic pt,
                      input logic [XL-1:0] lk);
        step(1'b1, 1'b1, f3, a, b, pc, tgt, pt, 1'b0, lk);
    endtask

    task automatic idle(input logic [XL-1:0] lk);
        step(1'b0, 1'b0, 3'd0, '0, '0, '0, '0, 1'b0, 1'b0, lk);
    endtask

    initial begin
        logic [2:0] f3s [6];
        f3s[0] = 3'd0; f3s[1] = 3'd1; f3s[2] = 3'd4;
        f3s[3] = 3'd5; f3s[4] = 3'd6; f3s[5] = 3'd7;
        model_reset();

        // Reset state and lookups
        #12;
        lookup_pc_i = 32'h40;
        check_all(idle_exp());
        lookup_pc_i = 32'h1234;
        #1;
        chk("lookup_after_reset", 64'(lookup_taken_o), 64'd0);
        @(posedge clk);
        #1;
        rst_ni = 1'b1;
        idle(32'h40);

        // Signed vs unsigned compare of 0xFFFFFFFF against 1
        br(3'd4, 32'hFFFF_FFFF, 32'd1, 32'h84, 32'h100, 1'b0, 32'h84);
        br(3'd6, 32'hFFFF_FFFF, 32'd1, 32'h84, 32'h100, 1'b0, 32'h84);
        br(3'd5, 32'h8000_0000, 32'h7FFF_FFFF, 32'h88, 32'h300, 1'b1, 32'h84);
        br(3'd7, 32'h8000_0000, 32'h7FFF_FFFF, 32'h88, 32'h300, 1'b1, 32'h84);

        // Training at 0x40: three taken, then two not-taken
        br(3'd0, 32'd5, 32'd5, 32'h40, 32'h400, 1'b1, 32'h40);
        br(3'd0, 32'd5, 32'd5, 32'h40, 32'h400, 1'b1, 32'h40);
        br(3'd0, 32'd5, 32'd5, 32'h40, 32'h400, 1'b1, 32'h40);
        br(3'd0, 32'd5, 32'd6, 32'h40, 32'h400, 1'b1, 32'h40);
        br(3'd0, 32'd5, 32'd6, 32'h40, 32'h400, 1'b0, 32'h40);
        idle(32'h40);
        idle(32'h40);

        // PC+4 wraps to zero on a mispredicted not-taken BNE
        br(3'd1, 32'd7, 32'd7, 32'hFFFF_FFFC, 32'h500, 1'b1, 32'hFFFF_FFFC);
        idle(32'hFFFF_FFFC);

        // Flush squashes the presented instruction only
        step(1'b1, 1'b1, 3'd0, 32'd1, 32'd1, 32'h48, 32'h600, 1'b0, 1'b1, 32'h48);
        step(1'b1, 1'b0, 3'd0, 32'd1, 32'd1, 32'h48, 32'h600, 1'b0, 1'b0, 32'h48);
        br(3'd5, 32'd5, 32'd5, 32'h48, 32'h600, 1'b0, 32'h48);
        step(1'b1, 1'b1, 3'd0, 32'd1, 32'd1, 32'h48, 32'h600, 1'b0, 1'b1, 32'h48);
        idle(32'h48);

        // Illegal funct3 leaves a trained BHT entry alone
        br(3'd7, 32'd9, 32'd3, 32'h4C, 32'h700, 1'b0, 32'h4C);
        br(3'd7, 32'd9, 32'd3, 32'h4C, 32'h700, 1'b1, 32'h4C);
        br(3'd2, 32'd9, 32'd3, 32'h4C, 32'h700, 1'b1, 32'h4C);
        br(3'd3, 32'd9, 32'd9, 32'h4C, 32'h700, 1'b1, 32'h4C);
        br(3'd2, 32'd1, 32'd2, 32'h4C, 32'h700, 1'b0, 32'h4C);
        idle(32'h4C);
        idle(32'h4C);

        // Mixed operand sweep across all six conditions
        for (int i = 0; i < 24; i++) begin
            logic [XL-1:0] a;
            logic [XL-1:0] b;
            a = $urandom;
            b = (i % 4 == 0) ? a : $urandom;
            br(f3s[i % 6], a, b, 32'h1000 + 32'(i * 4), 32'h2000 + 32'(i),
               1'($urandom_range(0, 1)), 32'h1000 + 32'(i * 4));
        end

        // Drive both statistics counters into saturation
        for (int i = 0; i < 70; i++) begin
            br(3'd0, 32'd1, 32'd2, 32'h200 + 32'(i * 4), 32'h800, 1'b1, 32'h4C);
        end
        idle(32'h4C);
        chk("branch_cnt_saturated",  64'(branch_cnt_o),  64'(CMAX));
        chk("mispred_cnt_saturated", 64'(mispred_cnt_o), 64'(CMAX));

        // Asynchronous reset while a result is on the outputs
        br(3'd0, 32'd3, 32'd3, 32'h4C, 32'h900, 1'b0, 32'h4C);
        rst_ni = 1'b0;
        #1;
        model_reset();
        check_all(idle_exp());
        valid_i = 1'b0;
        branch_i = 1'b0;
        @(posedge clk);
        #1;
        rst_ni = 1'b1;
        idle(32'h4C);
        br(3'd0, 32'd3, 32'd3, 32'h4C, 32'h900, 1'b0, 32'h4C);
        idle(32'h4C);
        idle(32'h4C);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
